// File: rtl/apu_dmc_if.sv
// DMC sample-fetch handshake between the DMC channel (master) and the DMA controller (slave).
interface apu_dmc_if;
  logic        dma_req;
  logic [15:0] dma_addr;
  logic        dma_ack;
  logic [7:0]  dma_data;

  modport master (output dma_req, output dma_addr, input dma_ack, input dma_data);
  modport slave  (input dma_req, input dma_addr, output dma_ack, output dma_data);
endinterface

// File: rtl/apu_dmc.sv
// APU delta-modulation channel: $4010-$4013 registers, rate timer, 1-bit delta
// output unit and the memory reader that requests sample bytes over the DMA handshake.
module apu_dmc (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  input  logic       reg_write,
  input  logic [1:0] reg_addr,
  input  logic [7:0] reg_data,
  input  logic       enable_write,
  input  logic       enable_bit,
  apu_dmc_if.master  dma,
  output logic [6:0] sample,
  output logic       active,
  output logic       irq
);

  logic        irq_en;
  logic        loop_flag;
  logic [3:0]  rate;
  logic [15:0] sample_base;
  logic [11:0] sample_len;
  logic [15:0] cur_addr;
  logic [11:0] bytes_remaining;
  logic [7:0]  buffer;
  logic        buffer_empty;
  logic [7:0]  shift;
  logic [3:0]  bits_remaining;
  logic        silence;
  logic [8:0]  timer;

  logic        req;
  logic        tick;
  logic        ack_ok;
  logic [8:0]  timer_nxt;
  logic [6:0]  sample_step;
  logic [15:0] addr_inc;
  logic [11:0] bytes_dec;

  function automatic logic [8:0] rate_period(input logic [3:0] r);
    case (r)
      4'd0:    rate_period = 9'd428;
      4'd1:    rate_period = 9'd380;
      4'd2:    rate_period = 9'd340;
      4'd3:    rate_period = 9'd320;
      4'd4:    rate_period = 9'd286;
      4'd5:    rate_period = 9'd254;
      4'd6:    rate_period = 9'd226;
      4'd7:    rate_period = 9'd214;
      4'd8:    rate_period = 9'd190;
      4'd9:    rate_period = 9'd160;
      4'd10:   rate_period = 9'd142;
      4'd11:   rate_period = 9'd128;
      4'd12:   rate_period = 9'd106;
      4'd13:   rate_period = 9'd84;
      4'd14:   rate_period = 9'd72;
      default: rate_period = 9'd54;
    endcase
  endfunction

  assign req          = buffer_empty && (bytes_remaining != '0);
  assign dma.dma_req  = req;
  assign dma.dma_addr = cur_addr;
  assign active       = (bytes_remaining != '0);

  always_comb begin
    tick      = (timer == '0);
    timer_nxt = tick ? rate_period(rate) - 9'd1 : timer - 9'd1;
    ack_ok    = dma.dma_ack && req;
    addr_inc  = (cur_addr == 16'hFFFF) ? 16'h8000 : cur_addr + 16'd1;
    bytes_dec = bytes_remaining - 12'd1;

    sample_step = sample;
    if (!silence) begin
      if (shift[0] && sample <= 7'd125)
        sample_step = sample + 7'd2;
      else if (!shift[0] && sample >= 7'd2)
        sample_step = sample - 7'd2;
    end
  end

  // Later assignments in this block take priority: CPU writes override the
  // output unit and the reader when they collide in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_en          <= 1'b0;
      loop_flag       <= 1'b0;
      rate            <= '0;
      sample          <= '0;
      sample_base     <= 16'hC000;
      sample_len      <= 12'd1;
      cur_addr        <= 16'hC000;
      bytes_remaining <= '0;
      buffer          <= '0;
      buffer_empty    <= 1'b1;
      shift           <= '0;
      bits_remaining  <= 4'd8;
      silence         <= 1'b1;
      timer           <= 9'd427;
      irq             <= 1'b0;
    end else if (ce) begin
      timer <= timer_nxt;

      if (tick) begin
        sample <= sample_step;
        shift  <= shift >> 1;
        if (bits_remaining == 4'd1) begin
          bits_remaining <= 4'd8;
          if (buffer_empty) begin
            silence <= 1'b1;
          end else begin
            silence      <= 1'b0;
            shift        <= buffer;
            buffer_empty <= 1'b1;
          end
        end else begin
          bits_remaining <= bits_remaining - 4'd1;
        end
      end

      if (ack_ok) begin
        buffer       <= dma.dma_data;
        buffer_empty <= 1'b0;
        if (bytes_remaining == 12'd1) begin
          if (loop_flag) begin
            cur_addr        <= sample_base;
            bytes_remaining <= sample_len;
          end else begin
            cur_addr        <= addr_inc;
            bytes_remaining <= '0;
            if (irq_en)
              irq <= 1'b1;
          end
        end else begin
          cur_addr        <= addr_inc;
          bytes_remaining <= bytes_dec;
        end
      end

      if (reg_write) begin
        case (reg_addr)
          2'd0: begin
            irq_en    <= reg_data[7];
            loop_flag <= reg_data[6];
            rate      <= reg_data[3:0];
            if (!reg_data[7])
              irq <= 1'b0;
          end
          2'd1: sample      <= reg_data[6:0];
          2'd2: sample_base <= {2'b11, reg_data, 6'b0};
          default: sample_len <= {reg_data, 4'b0001};
        endcase
      end

      if (enable_write) begin
        irq <= 1'b0;
        if (!enable_bit) begin
          bytes_remaining <= '0;
        end else if (bytes_remaining == '0) begin
          cur_addr        <= sample_base;
          bytes_remaining <= sample_len;
        end
      end
    end
  end

endmodule

// File: tb/tb_apu_dmc.sv
// Directed bench for apu_dmc: register writes, reader handshake, output unit and timer.
module tb_apu_dmc;
  logic       clk = 1'b0;
  logic       reset;
  logic       ce;
  logic       reg_write;
  logic [1:0] reg_addr;
  logic [7:0] reg_data;
  logic       enable_write;
  logic       enable_bit;
  logic [6:0] sample;
  logic       active;
  logic       irq;

  int unsigned edges;
  int          checks;
  int          fails;

  apu_dmc_if dma();

  apu_dmc dut (
    .clk          (clk),
    .reset        (reset),
    .ce           (ce),
    .reg_write    (reg_write),
    .reg_addr     (reg_addr),
    .reg_data     (reg_data),
    .enable_write (enable_write),
    .enable_bit   (enable_bit),
    .dma          (dma),
    .sample       (sample),
    .active       (active),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    if (ce && !reset) edges++;
  endtask

  task automatic run_to(input int unsigned n);
    while (edges < n) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    edges = 0;
  endtask

  task automatic write_reg(input logic [1:0] a, input logic [7:0] d);
    reg_write = 1'b1;
    reg_addr  = a;
    reg_data  = d;
    step();
    reg_write = 1'b0;
  endtask

  task automatic write_en(input logic b);
    enable_write = 1'b1;
    enable_bit   = b;
    step();
    enable_write = 1'b0;
  endtask

  task automatic do_ack(input logic [7:0] d);
    dma.dma_ack  = 1'b1;
    dma.dma_data = d;
    step();
    dma.dma_ack  = 1'b0;
  endtask

  // Edges 1..5 are register writes, edge 6 acks the single byte; rate timer
  // still runs its 428-cycle post-reset period, so output clocks land at 428+54k.
  task automatic setup_play(input logic [7:0] ctrl, input logic [7:0] init,
                            input logic [7:0] data, input logic dis);
    do_reset();
    write_reg(2'd0, ctrl);
    write_reg(2'd1, init);
    write_reg(2'd2, 8'h00);
    write_reg(2'd3, 8'h00);
    write_en(1'b1);
    dma.dma_ack  = 1'b1;
    dma.dma_data = data;
    if (dis) begin
      enable_write = 1'b1;
      enable_bit   = 1'b0;
    end
    step();
    dma.dma_ack  = 1'b0;
    enable_write = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (sample !== 7'h00) begin fails++; $display("FAIL reset_sample: got %h want 00", sample); end
    checks++; if (dma.dma_req !== 1'b0) begin fails++; $display("FAIL reset_req: got %b want 0", dma.dma_req); end
    checks++; if (dma.dma_addr !== 16'hC000) begin fails++; $display("FAIL reset_addr: got %h want C000", dma.dma_addr); end
    checks++; if (active !== 1'b0) begin fails++; $display("FAIL reset_active: got %b want 0", active); end
    checks++; if (irq !== 1'b0) begin fails++; $display("FAIL reset_irq: got %b want 0", irq); end
    write_en(1'b1);
    checks++; if (dma.dma_req !== 1'b1) begin fails++; $display("FAIL default_req: got %b want 1", dma.dma_req); end
    checks++; if (active !== 1'b1) begin fails++; $display("FAIL default_active: got %b want 1", active); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (dma.dma_req !== 1'b0) begin fails++; $display("FAIL reset_mid_dma: got %b want 0", dma.dma_req); end
  endtask

  task automatic test_oneshot();
    do_reset();
    write_reg(2'd0, 8'h0F);
    write_reg(2'd2, 8'h01);
    write_reg(2'd3, 8'h00);
    checks++; if (dma.dma_req !== 1'b0) begin fails++; $display("FAIL oneshot_idle_req: got %b want 0", dma.dma_req); end
    write_en(1'b1);
    checks++; if (dma.dma_req !== 1'b1) begin fails++; $display("FAIL oneshot_req: got %b want 1", dma.dma_req); end
    checks++; if (dma.dma_addr !== 16'hC040) begin fails++; $display("FAIL oneshot_addr: got %h want C040", dma.dma_addr); end
    do_ack(8'hFF);
    checks++; if (active !== 1'b0) begin fails++; $display("FAIL oneshot_active: got %b want 0", active); end
    checks++; if (dma.dma_req !== 1'b0) begin fails++; $display("FAIL oneshot_req_after: got %b want 0", dma.dma_req); end
    checks++; if (irq !== 1'b0) begin fails++; $display("FAIL oneshot_irq: got %b want 0", irq); end
    checks++; if (dma.dma_addr !== 16'hC041) begin fails++; $display("FAIL oneshot_addr_inc: got %h want C041", dma.dma_addr); end
  endtask

  task automatic test_irq();
    do_reset();
    write_reg(2'd0, 8'h8F);
    write_reg(2'd2, 8'h01);
    write_reg(2'd3, 8'h00);
    write_en(1'b1);
    do_ack(8'hFF);
    checks++; if (irq !== 1'b1) begin fails++; $display("FAIL irq_set: got %b want 1", irq); end
    write_en(1'b0);
    checks++; if (irq !== 1'b0) begin fails++; $display("FAIL irq_clr_4015: got %b want 0", irq); end
    do_ack(8'h55);
    checks++; if (dma.dma_addr !== 16'hC041) begin fails++; $display("FAIL stray_ack_addr: got %h want C041", dma.dma_addr); end
    checks++; if (irq !== 1'b0) begin fails++; $display("FAIL stray_ack_irq: got %b want 0", irq); end
    write_en(1'b1);
    checks++; if (dma.dma_addr !== 16'hC040) begin fails++; $display("FAIL irq_restart_addr: got %h want C040", dma.dma_addr); end
    do_ack(8'hFF);
    write_reg(2'd0, 8'h0F);
    checks++; if (irq !== 1'b0) begin fails++; $display("FAIL irq_clr_4010: got %b want 0", irq); end
  endtask

  task automatic test_loop();
    do_reset();
    write_reg(2'd0, 8'h4F);
    write_reg(2'd2, 8'h01);
    write_reg(2'd3, 8'h00);
    write_en(1'b1);
    do_ack(8'hFF);
    checks++; if (dma.dma_addr !== 16'hC040) begin fails++; $display("FAIL loop_addr: got %h want C040", dma.dma_addr); end
    checks++; if (active !== 1'b1) begin fails++; $display("FAIL loop_active: got %b want 1", active); end
    checks++; if (irq !== 1'b0) begin fails++; $display("FAIL loop_irq: got %b want 0", irq); end
    run_to(805);
    checks++; if (dma.dma_req !== 1'b0) begin fails++; $display("FAIL loop_req_full: got %b want 0", dma.dma_req); end
    run_to(806);
    checks++; if (dma.dma_req !== 1'b1) begin fails++; $display("FAIL loop_req_refill: got %b want 1", dma.dma_req); end
  endtask

  task automatic test_sample_up();
    setup_play(8'h0F, 8'h40, 8'hFF, 1'b0);
    run_to(806);
    checks++; if (sample !== 7'h40) begin fails++; $display("FAIL up_silent: got %h want 40", sample); end
    run_to(859);
    checks++; if (sample !== 7'h40) begin fails++; $display("FAIL up_before: got %h want 40", sample); end
    run_to(860);
    checks++; if (sample !== 7'h42) begin fails++; $display("FAIL up_first: got %h want 42", sample); end
    run_to(913);
    checks++; if (sample !== 7'h42) begin fails++; $display("FAIL up_hold: got %h want 42", sample); end
    run_to(914);
    checks++; if (sample !== 7'h44) begin fails++; $display("FAIL up_second: got %h want 44", sample); end
  endtask

  task automatic test_sample_down();
    setup_play(8'h0F, 8'h03, 8'h00, 1'b0);
    run_to(860);
    checks++; if (sample !== 7'h01) begin fails++; $display("FAIL down_step: got %h want 01", sample); end
    run_to(914);
    checks++; if (sample !== 7'h01) begin fails++; $display("FAIL down_floor: got %h want 01", sample); end
  endtask

  task automatic test_sample_high();
    setup_play(8'h0F, 8'h7D, 8'hFF, 1'b0);
    run_to(860);
    checks++; if (sample !== 7'h7F) begin fails++; $display("FAIL high_step: got %h want 7F", sample); end
    run_to(914);
    checks++; if (sample !== 7'h7F) begin fails++; $display("FAIL high_ceiling: got %h want 7F", sample); end
    setup_play(8'h0F, 8'h7E, 8'hFF, 1'b0);
    run_to(860);
    checks++; if (sample !== 7'h7E) begin fails++; $display("FAIL high_7e: got %h want 7E", sample); end
  endtask

  task automatic test_write_wins();
    setup_play(8'h0F, 8'h40, 8'hFF, 1'b0);
    run_to(859);
    write_reg(2'd1, 8'h20);
    checks++; if (sample !== 7'h20) begin fails++; $display("FAIL write_wins: got %h want 20", sample); end
    run_to(914);
    checks++; if (sample !== 7'h22) begin fails++; $display("FAIL write_then_tick: got %h want 22", sample); end
  endtask

  task automatic test_disable_on_ack();
    setup_play(8'h8F, 8'h40, 8'hFF, 1'b1);
    checks++; if (active !== 1'b0) begin fails++; $display("FAIL dis_active: got %b want 0", active); end
    checks++; if (dma.dma_req !== 1'b0) begin fails++; $display("FAIL dis_req: got %b want 0", dma.dma_req); end
    checks++; if (irq !== 1'b0) begin fails++; $display("FAIL dis_irq: got %b want 0", irq); end
    run_to(860);
    checks++; if (sample !== 7'h42) begin fails++; $display("FAIL dis_plays: got %h want 42", sample); end
  endtask

  task automatic test_rate_change_and_ce();
    do_reset();
    write_reg(2'd1, 8'h40);
    write_reg(2'd2, 8'h00);
    write_reg(2'd3, 8'h01);
    write_en(1'b1);
    do_ack(8'hFF);
    run_to(499);
    write_reg(2'd0, 8'h0F);
    run_to(1179);
    checks++; if (dma.dma_req !== 1'b0) begin fails++; $display("FAIL rate_req_before: got %b want 0", dma.dma_req); end
    run_to(1180);
    checks++; if (dma.dma_req !== 1'b1) begin fails++; $display("FAIL rate_req_refill: got %b want 1", dma.dma_req); end
    do_ack(8'hFF);
    run_to(1233);
    checks++; if (sample !== 7'h40) begin fails++; $display("FAIL rate_sample_before: got %h want 40", sample); end
    run_to(1234);
    checks++; if (sample !== 7'h42) begin fails++; $display("FAIL rate_sample_tick: got %h want 42", sample); end
    ce = 1'b0;
    write_reg(2'd1, 8'h10);
    repeat (100) step();
    checks++; if (sample !== 7'h42) begin fails++; $display("FAIL ce_freeze_sample: got %h want 42", sample); end
    checks++; if (dma.dma_addr !== 16'hC002) begin fails++; $display("FAIL ce_freeze_addr: got %h want C002", dma.dma_addr); end
    ce = 1'b1;
    run_to(1287);
    checks++; if (sample !== 7'h42) begin fails++; $display("FAIL ce_resume_hold: got %h want 42", sample); end
    run_to(1288);
    checks++; if (sample !== 7'h44) begin fails++; $display("FAIL ce_resume_tick: got %h want 44", sample); end
  endtask

  task automatic test_length();
    do_reset();
    write_reg(2'd0, 8'h0F);
    write_reg(2'd2, 8'hFF);
    write_reg(2'd3, 8'h01);
    write_en(1'b1);
    for (int i = 0; i < 17; i++) begin
      int w;
      w = 0;
      while (dma.dma_req !== 1'b1 && w < 1000) begin step(); w++; end
      if (dma.dma_req !== 1'b1) begin
        checks++; fails++;
        $display("FAIL len_req_timeout: byte %0d got req %b want 1", i, dma.dma_req);
        return;
      end
      do_ack(8'hAA);
      if (i == 15) begin
        checks++; if (active !== 1'b1) begin fails++; $display("FAIL len_active_16: got %b want 1", active); end
      end
    end
    checks++; if (active !== 1'b0) begin fails++; $display("FAIL len_active_17: got %b want 0", active); end
    checks++; if (dma.dma_addr !== 16'hFFD1) begin fails++; $display("FAIL len_end_addr: got %h want FFD1", dma.dma_addr); end
  endtask

  task automatic test_addr_wrap();
    do_reset();
    write_reg(2'd0, 8'h0F);
    write_reg(2'd2, 8'hFF);
    write_reg(2'd3, 8'h04);
    write_en(1'b1);
    for (int i = 0; i < 65; i++) begin
      int w;
      logic [15:0] exp_addr;
      w = 0;
      exp_addr = (i < 64) ? 16'hFFC0 + 16'(i) : 16'h8000;
      while (dma.dma_req !== 1'b1 && w < 1000) begin step(); w++; end
      if (dma.dma_req !== 1'b1) begin
        checks++; fails++;
        $display("FAIL wrap_req_timeout: byte %0d got req %b want 1", i, dma.dma_req);
        return;
      end
      checks++;
      if (dma.dma_addr !== exp_addr) begin
        fails++; $display("FAIL wrap_addr: byte %0d got %h want %h", i, dma.dma_addr, exp_addr);
      end
      do_ack(8'h0F);
    end
    checks++; if (active !== 1'b0) begin fails++; $display("FAIL wrap_active: got %b want 0", active); end
    checks++; if (dma.dma_addr !== 16'h8001) begin fails++; $display("FAIL wrap_end_addr: got %h want 8001", dma.dma_addr); end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    checks       = 0;
    fails        = 0;
    edges        = 0;
    reset        = 1'b1;
    ce           = 1'b1;
    reg_write    = 1'b0;
    reg_addr     = '0;
    reg_data     = '0;
    enable_write = 1'b0;
    enable_bit   = 1'b0;
    dma.dma_ack  = 1'b0;
    dma.dma_data = '0;

    test_reset();
    test_oneshot();
    test_irq();
    test_loop();
    test_sample_up();
    test_sample_down();
    test_sample_high();
    test_write_wins();
    test_disable_on_ack();
    test_rate_change_and_ce();
    test_length();
    test_addr_wrap();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
